// File: rtl/ddram_arb_pkg.sv
// ddram_arb_pkg: shared state encoding, burst-count width and owner encoding for the DDR3 arbiter.
package ddram_arb_pkg;
    localparam int BCW = 8;
    typedef logic [1:0] state_t;
    localparam state_t IDLE     = 2'd0;
    localparam state_t GNT      = 2'd1;
    localparam state_t WR_BURST = 2'd2;
    localparam state_t RD_DATA  = 2'd3;
    localparam logic OWN_A = 1'b0;
    localparam logic OWN_B = 1'b1;
endpackage

// File: rtl/ddram_rr2.sv
// ddram_rr2: two-way round-robin selector; on a tie the requester not served last wins.
module ddram_rr2 (
    input  logic [1:0] req,
    input  logic       last,
    output logic       gnt
);
    always_comb gnt = (&req) ? ~last : req[1];
endmodule

// File: rtl/ddram_arb.sv
// ddram_arb: arbitrates two burst requesters onto one DDR3 Avalon-style port,
// holding one read burst outstanding at a time.
module ddram_arb
    import ddram_arb_pkg::*;
#(
    parameter int AW = 29,
    parameter int DW = 64
) (
    input  logic              clk_sys,
    input  logic              reset_n,
    input  logic [AW-1:0]     a_addr,
    input  logic [BCW-1:0]    a_burstcnt,
    input  logic              a_rd,
    input  logic              a_we,
    input  logic [DW-1:0]     a_din,
    input  logic [DW/8-1:0]   a_be,
    output logic [DW-1:0]     a_dout,
    output logic              a_dout_ready,
    output logic              a_busy,
    input  logic [AW-1:0]     b_addr,
    input  logic [BCW-1:0]    b_burstcnt,
    input  logic              b_rd,
    input  logic              b_we,
    input  logic [DW-1:0]     b_din,
    input  logic [DW/8-1:0]   b_be,
    output logic [DW-1:0]     b_dout,
    output logic              b_dout_ready,
    output logic              b_busy,
    output logic [AW-1:0]     ram_address,
    output logic [BCW-1:0]    ram_burstcount,
    output logic              ram_read,
    output logic              ram_write,
    output logic [DW-1:0]     ram_writedata,
    output logic [DW/8-1:0]   ram_byteenable,
    input  logic              ram_waitrequest,
    input  logic [DW-1:0]     ram_readdata,
    input  logic              ram_readdatavalid
);
    state_t         state_q, state_d;
    logic           own_q, own_d, last_q, last_d, gnt;
    logic [BCW-1:0] beat_q, beat_d, len_q, len_d, o_bc, bc1, nxt;
    logic           o_rd, o_we, act, wacc, racc, rdv;

    ddram_rr2 u_rr (
        .req  ({b_rd | b_we, a_rd | a_we}),
        .last (last_q),
        .gnt  (gnt)
    );

    assign o_rd           = own_q ? b_rd : a_rd;
    assign o_we           = own_q ? b_we : a_we;
    assign o_bc           = own_q ? b_burstcnt : a_burstcnt;
    assign bc1            = (o_bc == '0) ? BCW'(1) : o_bc;
    assign nxt            = beat_q + 1'b1;
    assign act            = (state_q == GNT) || (state_q == WR_BURST);
    assign wacc           = o_we & ~ram_waitrequest;
    assign racc           = o_rd & ~ram_waitrequest;
    assign ram_address    = own_q ? b_addr : a_addr;
    assign ram_writedata  = own_q ? b_din : a_din;
    assign ram_byteenable = own_q ? b_be : a_be;
    assign ram_burstcount = bc1;
    // A write wins over a simultaneous read; reads are only issued from GNT.
    assign ram_read       = (state_q == GNT) & o_rd & ~o_we;
    assign ram_write      = act & o_we;
    assign a_busy         = ~act | (own_q != OWN_A) | ram_waitrequest;
    assign b_busy         = ~act | (own_q != OWN_B) | ram_waitrequest;
    assign rdv            = (state_q == RD_DATA) & ram_readdatavalid;
    assign a_dout_ready   = rdv & (own_q == OWN_A);
    assign b_dout_ready   = rdv & (own_q == OWN_B);
    assign a_dout         = ram_readdata;
    assign b_dout         = ram_readdata;

    always_comb begin
        state_d = state_q;
        own_d   = own_q;
        last_d  = last_q;
        beat_d  = beat_q;
        len_d   = len_q;
        case (state_q)
            IDLE: if (a_rd | a_we | b_rd | b_we) begin
                own_d   = gnt;
                state_d = GNT;
            end
            GNT: if (wacc) begin
                len_d   = bc1;
                beat_d  = BCW'(1);
                state_d = (bc1 == BCW'(1)) ? IDLE : WR_BURST;
                last_d  = (bc1 == BCW'(1)) ? own_q : last_q;
            end else if (racc) begin
                len_d   = bc1;
                beat_d  = '0;
                state_d = RD_DATA;
            end else if (!o_rd && !o_we) begin
                state_d = IDLE;
            end
            WR_BURST: if (wacc) begin
                beat_d  = nxt;
                state_d = (nxt == len_q) ? IDLE : WR_BURST;
                last_d  = (nxt == len_q) ? own_q : last_q;
            end
            RD_DATA: if (ram_readdatavalid) begin
                beat_d  = nxt;
                state_d = (nxt == len_q) ? IDLE : RD_DATA;
                last_d  = (nxt == len_q) ? own_q : last_q;
            end
            default: state_d = IDLE;
        endcase
    end

    // last_q resets to B so that A wins the first tie.
    always_ff @(posedge clk_sys or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= IDLE;
            own_q   <= OWN_A;
            last_q  <= OWN_B;
            beat_q  <= '0;
            len_q   <= '0;
        end else begin
            state_q <= state_d;
            own_q   <= own_d;
            last_q  <= last_d;
            beat_q  <= beat_d;
            len_q   <= len_d;
        end
    end
endmodule

// File: tb/tb_ddram_arb.sv
// tb_ddram_arb: directed scenario tests for the two-port DDR3 arbiter.
module tb_ddram_arb;
    localparam int AW = 29;
    localparam int DW = 64;

    logic clk_sys = 1'b0, reset_n = 1'b0;
    logic [AW-1:0] a_addr = '0, b_addr = '0, ram_address;
    logic [7:0] a_burstcnt = '0, b_burstcnt = '0, ram_burstcount;
    logic a_rd = 0, a_we = 0, b_rd = 0, b_we = 0;
    logic [DW-1:0] a_din = '0, b_din = '0, a_dout, b_dout, ram_writedata, ram_readdata = '0;
    logic [DW/8-1:0] a_be = '0, b_be = '0, ram_byteenable;
    logic a_dout_ready, b_dout_ready, a_busy, b_busy, ram_read, ram_write;
    logic ram_waitrequest = 0, ram_readdatavalid = 0;
    int vec = 0, err = 0;

    always #5 clk_sys = ~clk_sys;

    ddram_arb #(.AW(AW), .DW(DW)) dut (
        .clk_sys(clk_sys), .reset_n(reset_n),
        .a_addr(a_addr), .a_burstcnt(a_burstcnt), .a_rd(a_rd), .a_we(a_we),
        .a_din(a_din), .a_be(a_be), .a_dout(a_dout), .a_dout_ready(a_dout_ready), .a_busy(a_busy),
        .b_addr(b_addr), .b_burstcnt(b_burstcnt), .b_rd(b_rd), .b_we(b_we),
        .b_din(b_din), .b_be(b_be), .b_dout(b_dout), .b_dout_ready(b_dout_ready), .b_busy(b_busy),
        .ram_address(ram_address), .ram_burstcount(ram_burstcount), .ram_read(ram_read),
        .ram_write(ram_write), .ram_writedata(ram_writedata), .ram_byteenable(ram_byteenable),
        .ram_waitrequest(ram_waitrequest), .ram_readdata(ram_readdata),
        .ram_readdatavalid(ram_readdatavalid)
    );

    task automatic tick;
        @(posedge clk_sys);
        #1;
    endtask

    task automatic test_reset;
        a_rd = 1;
        ram_readdatavalid = 1;
        tick;
        #1;
        vec++; if ({ram_read, ram_write} !== 2'b00) begin $display("FAIL reset_cmd got %b want 00", {ram_read, ram_write}); err++; end
        vec++; if ({a_busy, b_busy} !== 2'b11) begin $display("FAIL reset_busy got %b want 11", {a_busy, b_busy}); err++; end
        vec++; if ({a_dout_ready, b_dout_ready} !== 2'b00) begin $display("FAIL reset_rdy got %b want 00", {a_dout_ready, b_dout_ready}); err++; end
        a_rd = 0;
        ram_readdatavalid = 0;
        reset_n = 1;
        tick;
    endtask

    task automatic test_rr;
        a_we = 1; b_we = 1; a_burstcnt = 1; b_burstcnt = 1;
        a_addr = 29'h10; b_addr = 29'h20;
        a_din = 64'hAAAA_0000_1111_2222; b_din = 64'hBBBB_3333_4444_5555;
        a_be = 8'h0F; b_be = 8'hF0;
        #1;
        vec++; if ({a_busy, b_busy, ram_write} !== 3'b110) begin $display("FAIL rr_idle got %b want 110", {a_busy, b_busy, ram_write}); err++; end
        tick; #1;
        vec++; if (ram_address !== 29'h10 || ram_write !== 1'b1) begin $display("FAIL rr_first got addr %h wr %b want 10 1", ram_address, ram_write); err++; end
        vec++; if (ram_writedata !== a_din || ram_byteenable !== 8'h0F) begin $display("FAIL rr_a_data got %h/%h want %h/0f", ram_writedata, ram_byteenable, a_din); err++; end
        vec++; if ({a_busy, b_busy} !== 2'b01) begin $display("FAIL rr_a_busy got %b want 01", {a_busy, b_busy}); err++; end
        tick; #1;
        vec++; if (ram_write !== 1'b0) begin $display("FAIL rr_gap got %b want 0", ram_write); err++; end
        tick; #1;
        vec++; if (ram_address !== 29'h20 || ram_writedata !== b_din || ram_byteenable !== 8'hF0) begin $display("FAIL rr_second got %h/%h/%h want 20/%h/f0", ram_address, ram_writedata, ram_byteenable, b_din); err++; end
        vec++; if ({a_busy, b_busy} !== 2'b10) begin $display("FAIL rr_b_busy got %b want 10", {a_busy, b_busy}); err++; end
        tick;
        tick; #1;
        vec++; if (ram_address !== 29'h10 || ram_write !== 1'b1) begin $display("FAIL rr_third got addr %h wr %b want 10 1", ram_address, ram_write); err++; end
        tick;
        a_we = 0; b_we = 0;
        tick;
    endtask

    task automatic test_wait;
        logic [4:0] wr_sched;
        logic [4:0] want_bbusy;
        int acc;
        wr_sched = 5'b00110;
        want_bbusy = 5'b00110;
        acc = 0;
        b_we = 1; b_burstcnt = 3; b_addr = 29'h30;
        tick;
        for (int i = 0; i < 5; i++) begin
            ram_waitrequest = wr_sched[i];
            #1;
            vec++; if (a_busy !== 1'b1 || ram_write !== 1'b1 || b_busy !== want_bbusy[i]) begin
                $display("FAIL wait_cyc%0d got abusy %b wr %b bbusy %b want 1 1 %b", i, a_busy, ram_write, b_busy, want_bbusy[i]); err++; end
            if (ram_write && !ram_waitrequest) acc++;
            tick;
        end
        ram_waitrequest = 0;
        #1;
        vec++; if (acc !== 3) begin $display("FAIL wait_beats got %0d want 3", acc); err++; end
        vec++; if (ram_write !== 1'b0 || b_busy !== 1'b1) begin $display("FAIL wait_end got wr %b bbusy %b want 0 1", ram_write, b_busy); err++; end
        b_we = 0;
        tick;
    endtask

    task automatic test_read_burst;
        a_rd = 1; a_addr = 29'h100; a_burstcnt = 4;
        #1;
        vec++; if (ram_read !== 1'b0 || a_busy !== 1'b1) begin $display("FAIL rd_idle got rd %b busy %b want 0 1", ram_read, a_busy); err++; end
        tick; #1;
        vec++; if (ram_read !== 1'b1 || ram_address !== 29'h100 || ram_burstcount !== 8'd4) begin
            $display("FAIL rd_cmd got rd %b addr %h bc %0d want 1 100 4", ram_read, ram_address, ram_burstcount); err++; end
        vec++; if ({a_busy, b_busy} !== 2'b01) begin $display("FAIL rd_cmd_busy got %b want 01", {a_busy, b_busy}); err++; end
        tick;
        a_rd = 0;
        #1;
        vec++; if (ram_read !== 1'b0 || a_busy !== 1'b1) begin $display("FAIL rd_once got rd %b busy %b want 0 1", ram_read, a_busy); err++; end
        for (int i = 0; i < 4; i++) begin
            ram_readdatavalid = 1;
            ram_readdata = 64'hD000 + 64'(i);
            #1;
            vec++; if ({a_dout_ready, b_dout_ready} !== 2'b10 || a_dout !== 64'hD000 + 64'(i)) begin
                $display("FAIL rd_beat%0d got rdy %b dout %h want 10 %h", i, {a_dout_ready, b_dout_ready}, a_dout, 64'hD000 + 64'(i)); err++; end
            tick;
        end
        #1;
        vec++; if (a_dout_ready !== 1'b0) begin $display("FAIL rd_after got %b want 0", a_dout_ready); err++; end
        ram_readdatavalid = 0;
        tick;
    endtask

    task automatic test_bc0;
        a_rd = 1; a_addr = 29'h55; a_burstcnt = 0;
        tick; #1;
        vec++; if (ram_read !== 1'b1 || ram_burstcount !== 8'd1) begin $display("FAIL bc0_cmd got rd %b bc %0d want 1 1", ram_read, ram_burstcount); err++; end
        tick;
        a_rd = 0;
        ram_readdatavalid = 1;
        #1;
        vec++; if (a_dout_ready !== 1'b1) begin $display("FAIL bc0_beat got %b want 1", a_dout_ready); err++; end
        tick; #1;
        vec++; if (a_dout_ready !== 1'b0) begin $display("FAIL bc0_end got %b want 0", a_dout_ready); err++; end
        ram_readdatavalid = 0;
        tick;
    endtask

    task automatic test_reset_mid;
        a_rd = 1; a_addr = 29'h180; a_burstcnt = 4;
        tick;
        tick;
        a_rd = 0;
        ram_readdatavalid = 1;
        tick;
        tick;
        #2;
        reset_n = 0;
        #1;
        vec++; if ({a_dout_ready, b_dout_ready, a_busy, b_busy, ram_read, ram_write} !== 6'b001100) begin
            $display("FAIL rst_mid_async got %b want 001100", {a_dout_ready, b_dout_ready, a_busy, b_busy, ram_read, ram_write}); err++; end
        ram_readdatavalid = 0;
        tick;
        reset_n = 1;
        ram_readdatavalid = 1;
        for (int i = 0; i < 2; i++) begin
            #1;
            vec++; if ({a_dout_ready, b_dout_ready} !== 2'b00) begin $display("FAIL rst_mid_trail%0d got %b want 00", i, {a_dout_ready, b_dout_ready}); err++; end
            tick;
        end
        ram_readdatavalid = 0;
        a_rd = 1; a_addr = 29'h200; a_burstcnt = 2;
        tick; #1;
        vec++; if (ram_read !== 1'b1 || ram_address !== 29'h200 || ram_burstcount !== 8'd2) begin
            $display("FAIL rst_mid_next got rd %b addr %h bc %0d want 1 200 2", ram_read, ram_address, ram_burstcount); err++; end
        tick;
        a_rd = 0;
        ram_readdatavalid = 1;
        for (int i = 0; i < 2; i++) begin
            #1;
            vec++; if (a_dout_ready !== 1'b1) begin $display("FAIL rst_mid_beat%0d got %b want 1", i, a_dout_ready); err++; end
            tick;
        end
        ram_readdatavalid = 0;
        tick;
    endtask

    task automatic test_abort;
        a_we = 1; b_we = 1; a_burstcnt = 1; b_burstcnt = 1;
        a_addr = 29'h40; b_addr = 29'h50;
        ram_waitrequest = 1;
        tick; #1;
        vec++; if (ram_address !== 29'h50 || b_busy !== 1'b1) begin $display("FAIL abort_gnt got addr %h bbusy %b want 50 1", ram_address, b_busy); err++; end
        a_we = 0; b_we = 0;
        #1;
        vec++; if (ram_write !== 1'b0) begin $display("FAIL abort_drop got %b want 0", ram_write); err++; end
        tick;
        a_we = 1; b_we = 1;
        ram_waitrequest = 0;
        tick; #1;
        vec++; if (ram_address !== 29'h50 || {a_busy, b_busy} !== 2'b10) begin
            $display("FAIL abort_ptr got addr %h busy %b want 50 10", ram_address, {a_busy, b_busy}); err++; end
        tick;
        a_we = 0; b_we = 0;
        tick;
    endtask

    task automatic test_rdwe;
        a_rd = 1; a_we = 1; a_burstcnt = 1; a_addr = 29'h60;
        tick; #1;
        vec++; if ({ram_read, ram_write} !== 2'b01) begin $display("FAIL rdwe got %b want 01", {ram_read, ram_write}); err++; end
        tick;
        a_rd = 0; a_we = 0;
        #1;
        vec++; if ({ram_read, ram_write, a_busy} !== 3'b001) begin $display("FAIL rdwe_end got %b want 001", {ram_read, ram_write, a_busy}); err++; end
        tick;
    endtask

    initial begin
        test_reset;
        test_rr;
        test_wait;
        test_read_burst;
        test_bc0;
        test_reset_mid;
        test_abort;
        test_rdwe;
        $display("== %0d vectors applied, %0d miscompares ==", vec, err);
        $finish;
    end
endmodule

// File: doc/ddram_arb.md
DDRAM_ARB -- requirements
Module: ddram_arb

Interface
REQ-001 SHALL have parameter AW, default 29, meaning the DDR3 word address width.
REQ-002 SHALL have parameter DW, default 64, meaning the data width; byte-enable width is DW/8.
REQ-003 SHALL have port clk_sys, input, 1, the single clock; all logic is on its rising edge.
REQ-004 SHALL have port reset_n, input, 1, asynchronous active-low reset.
REQ-005 SHALL have ports a_addr/b_addr, input, AW, requester word address.
REQ-006 SHALL have ports a_burstcnt/b_burstcnt, input, 8, burst length in beats.
REQ-007 SHALL have ports a_rd/b_rd and a_we/b_we, input, 1, read and write requests, held while busy.
REQ-008 SHALL have ports a_din/b_din, input, DW, write data; a_be/b_be, input, DW/8, byte enables.
REQ-009 SHALL have ports a_dout/b_dout, output, DW, read data, both driven from ram_readdata.
REQ-010 SHALL have ports a_dout_ready/b_dout_ready, output, 1, read data valid.
REQ-011 SHALL have ports a_busy/b_busy, output, 1, wait request toward each requester.
REQ-012 SHALL have ports ram_address (AW), ram_burstcount (8), ram_read, ram_write, ram_writedata (DW) and ram_byteenable (DW/8) as outputs to the DDR3 port.
REQ-013 SHALL have ports ram_waitrequest (1), ram_readdata (DW) and ram_readdatavalid (1) as inputs from the DDR3 port.

Function
REQ-014 SHALL implement states IDLE, GNT, WR_BURST and RD_DATA.
REQ-015 IDLE: if any request (rd|we) is pending, SHALL select an owner round-robin, with the requester not served last winning a tie, then go to GNT next cycle.
REQ-016 IDLE: a_busy=b_busy=1 and ram_read=ram_write=0, giving one cycle of arbitration latency.
REQ-017 GNT/WR_BURST: ram_address, ram_burstcount, ram_writedata, ram_byteenable, ram_read and ram_write SHALL be combinational copies of the owner's inputs.
REQ-018 GNT/WR_BURST: owner busy SHALL equal ram_waitrequest; the non-owner busy SHALL be 1.
REQ-019 A burstcnt of 0 SHALL be presented to the DDR3 port as 1 and counted as 1.
REQ-020 If the owner asserts both rd and we, the request SHALL be treated as a write and ram_read forced to 0.
REQ-021 GNT with we & ~ram_waitrequest: SHALL latch burstcnt and set beat count to 1; go IDLE if the length is 1, else WR_BURST.
REQ-022 WR_BURST: each we & ~ram_waitrequest SHALL increment the beat count; when the count reaches the latched length, go IDLE.
REQ-023 GNT with rd & ~ram_waitrequest: SHALL latch burstcnt and go RD_DATA.
REQ-024 RD_DATA: ram_read=ram_write=0, both busy=1, owner dout_ready=ram_readdatavalid, non-owner dout_ready=0; go IDLE on the final beat.
REQ-025 The round-robin pointer SHALL update to the owner on every return to IDLE.
REQ-026 GNT with the owner dropping both rd and we before the first beat is accepted: SHALL return to IDLE with no beat counted and the pointer unchanged.
REQ-027 ram_readdatavalid outside RD_DATA SHALL be ignored and both dout_ready held at 0.
REQ-028 Only one read burst SHALL be outstanding at a time; no new command is issued until the read burst completes.

Reset
REQ-029 On reset_n low, asynchronously: state=IDLE, pointer=A-first, beat count=0, latched length=0.
REQ-030 Outputs during reset: ram_read=ram_write=0, a_busy=b_busy=1, dout_ready both 0.
REQ-031 Reset mid-burst SHALL abandon the burst; after release, beats still arriving are ignored per REQ-027.

Structure
REQ-032 Package ddram_arb_pkg SHALL hold the state enum, the 8-bit burst-count width constant and the owner encoding (OWN_A=0, OWN_B=1).
REQ-033 The round-robin selector SHALL be the single sub-module ddram_rr2 (inputs req[1:0] and last; output gnt); the datapath muxes stay in ddram_arb.

Verification
REQ-034 a_rd=1, a_addr=0x100, a_burstcnt=4, ram_waitrequest=0 -> one-cycle ram_read with address 0x100, burstcount 4; four readdatavalid beats reach a_dout_ready only; then IDLE.
REQ-035 a_we and b_we asserted in the same cycle after reset -> A is served first, B next; with both held continuously, grants alternate A,B,A.
REQ-036 b_we, burstcnt=3, ram_waitrequest high for 2 cycles on beat 2 -> exactly 3 ram_write beats accepted; a_busy=1 throughout.
REQ-037 a_rd with burstcnt=0 -> ram_burstcount=1; exactly one readdatavalid beat ends RD_DATA.
REQ-038 reset_n pulsed low after 2 of 4 read beats -> outputs immediately at reset values; the 2 trailing beats give a_dout_ready=0; the next request is served normally.
